// File: rtl/gnt_sched_if.sv
// Request/grant bundle between requesters (master) and the grant scheduler (slave).
interface gnt_sched_if #(
    parameter int N = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic [N-1:0]    starve;

    modport master (output req, input gnt, gnt_id, busy, starve);
    modport slave  (input req, output gnt, gnt_id, busy, starve);
endinterface

// File: rtl/gnt_sched.sv
// Round-robin N-channel grant scheduler issuing fixed-width one-hot pulses with a low gap.
// Optional per-channel starvation watchdog enabled by defining GNT_SCHED_WDOG_EN.
module gnt_sched #(
    parameter int N       = 4,
    parameter int GNT_LEN = 8,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    gnt_sched_if.slave  bus
);
    localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int LEN_W = (GNT_LEN > 0) ? $clog2(GNT_LEN + 1) : 1;
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             busy_q, busy_d;
    logic [ID_W-1:0]  winner;
    logic             arb;

    // First set request strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = ptr;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (r[idx]) pick = idx[ID_W-1:0];
        end
        return pick;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        arb     = 1'b0;
        winner  = rr_pick(bus.req, ptr_q);

        case (state_q)
            S_IDLE: begin
                if (|bus.req) arb = 1'b1;
            end
            S_GRANT: begin
                if (len_q == '0) begin
                    state_d = S_GAP;
                    gnt_d   = '0;
                    id_d    = '0;
                    gap_d   = GAP_W'(GAP - 1);
                end else begin
                    len_d = len_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (|bus.req) arb = 1'b1;
                    else          state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (arb) begin
            state_d       = S_GRANT;
            gnt_d         = '0;
            gnt_d[winner] = 1'b1;
            id_d          = winner;
            ptr_d         = winner;
            len_d         = LEN_W'(GNT_LEN - 1);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= ID_W'(N - 1);
            gnt_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = id_q;
    assign bus.busy   = busy_q;

`ifdef GNT_SCHED_WDOG_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [N-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic [N-1:0]             starve_q, starve_d;

    // A saturated counter only raises starve while the channel is still unserved,
    // so the flag stays cleared through the grant that serves it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wait_d[i]   = wait_q[i];
            starve_d[i] = starve_q[i];
            if (!bus.req[i] || gnt_q[i])                wait_d[i] = '0;
            else if (wait_q[i] != WAIT_W'(TIMEOUT))     wait_d[i] = wait_q[i] + 1'b1;
            if (gnt_d[i] && !gnt_q[i])                  starve_d[i] = 1'b0;
            else if (!gnt_q[i] && wait_q[i] == WAIT_W'(TIMEOUT)) starve_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_q   <= '0;
            starve_q <= '0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    assign bus.starve = starve_q;
`else
    assign bus.starve = '0;
`endif

endmodule

// File: tb/tb_gnt_sched.sv
// Bench for gnt_sched: directed scenarios with literal expectations plus randomized
// requests/resets checked every cycle against a pulse-level behavioural model.
module tb_gnt_sched;
    localparam int N       = 4;
    localparam int GNT_LEN = 8;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 20;   // short threshold so the watchdog actually fires
    localparam int ID_W    = $clog2(N);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    gnt_sched_if #(.N(N)) bus ();

    gnt_sched #(
        .N(N), .GNT_LEN(GNT_LEN), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cur_cyc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: channel currently holding a pulse (-1 none); held: pulse cycles so far;
    // lows: completed low cycles since the last pulse (saturates at GAP).
    int           m_owner = -1;
    int           m_held  = 0;
    int           m_lows  = GAP;
    int           m_ptr   = N - 1;
    int           m_wait[N];
    logic [N-1:0] m_starve = '0;
    bit           model_live = 1'b0;

    task automatic model_step();
        logic [N-1:0] r;
        int old_owner, lows1;
        r = bus.req;
        if (!reset) begin
            m_owner = -1; m_held = 0; m_lows = GAP; m_ptr = N - 1;
            m_starve = '0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            model_live = 1'b1;
            return;
        end
        if (!model_live) return;
        old_owner = m_owner;
        if (m_owner >= 0) begin
            if (m_held == GNT_LEN) begin m_owner = -1; m_lows = 0; end
            else m_held++;
        end else begin
            lows1 = m_lows + 1;
            if (lows1 >= GAP && r != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (r[(m_ptr + k) % N]) begin m_owner = (m_ptr + k) % N; break; end
                end
                m_ptr  = m_owner;
                m_held = 1;
            end else begin
                m_lows = (lows1 > GAP) ? GAP : lows1;
            end
        end
`ifdef GNT_SCHED_WDOG_EN
        for (int i = 0; i < N; i++) begin
            if (m_owner == i && old_owner != i)        m_starve[i] = 1'b0;
            else if (old_owner != i && m_wait[i] == TIMEOUT) m_starve[i] = 1'b1;
            if (r[i] && old_owner != i) m_wait[i] = (m_wait[i] < TIMEOUT) ? m_wait[i] + 1 : TIMEOUT;
            else                        m_wait[i] = 0;
        end
`endif
    endtask

    always @(posedge clk) model_step();

    function automatic logic [N-1:0] exp_gnt();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic logic [ID_W-1:0] exp_id();
        return (m_owner >= 0) ? ID_W'(m_owner) : '0;
    endfunction

    function automatic logic exp_busy();
        return (m_owner >= 0) || (m_lows < GAP);
    endfunction

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_live) begin
            check("cmp_gnt",    bus.gnt,    exp_gnt());
            check("cmp_gnt_id", bus.gnt_id, exp_id());
            check("cmp_busy",   bus.busy,   exp_busy());
            check("cmp_starve", bus.starve, m_starve);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Leaves the bench in cycle 0: outputs reset, req = r0 to be sampled at the next edge.
    task automatic do_reset(input logic [N-1:0] r0);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        check("rst_gnt",    bus.gnt,    '0);
        check("rst_gnt_id", bus.gnt_id, '0);
        check("rst_busy",   bus.busy,   1'b0);
        check("rst_starve", bus.starve, '0);
        reset   = 1'b1;
        bus.req = r0;
        cur_cyc = 0;
    endtask

    task automatic go_to(input int c);
        while (cur_cyc < c) begin
            @(negedge clk);
            cur_cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = '0;

        // Single request, dropped after being granted.
        do_reset(4'b0001);
        go_to(1);
        bus.req = '0;
        check("single_gnt_c1",  bus.gnt,    4'b0001);
        check("single_id_c1",   bus.gnt_id, 0);
        check("single_busy_c1", bus.busy,   1'b1);
        check("model_owner_c1", 64'(m_owner), 0);
        go_to(8);
        check("single_gnt_c8",  bus.gnt,  4'b0001);
        go_to(9);
        check("single_gnt_c9",  bus.gnt,  4'b0000);
        check("single_busy_c9", bus.busy, 1'b1);
        go_to(10);
        check("single_busy_c10", bus.busy, 1'b0);
        check("model_busy_c10",  64'(exp_busy()), 0);

        // All requesting: round-robin 0,1,2,3,0 with one-cycle gaps.
        do_reset(4'b1111);
        for (int p = 0; p < 5; p++) begin
            go_to(1 + 9 * p);
            check("rr_start_gnt", bus.gnt,    4'b0001 << (p % 4));
            check("rr_start_id",  bus.gnt_id, p % 4);
            go_to(8 + 9 * p);
            check("rr_end_gnt",   bus.gnt,    4'b0001 << (p % 4));
            go_to(9 + 9 * p);
            check("rr_gap_gnt",   bus.gnt,    4'b0000);
        end

`ifdef GNT_SCHED_WDOG_EN
        // Channel 3 waits 27 cycles with all requesting: starve at 21, cleared at 28.
        do_reset(4'b1111);
        go_to(20);
        check("wdog_c20", bus.starve, 4'b0000);
        go_to(21);
        check("wdog_c21", bus.starve, 4'b1000);
        go_to(27);
        check("wdog_c27", bus.starve, 4'b1000);
        go_to(28);
        check("wdog_c28", bus.starve, 4'b0000);
        check("wdog_gnt_c28", bus.gnt, 4'b1000);
`endif

        // Request dropped mid-grant: pulse keeps its full width.
        do_reset(4'b0100);
        go_to(1);
        check("drop_gnt_c1", bus.gnt, 4'b0100);
        go_to(3);
        bus.req = '0;
        go_to(8);
        check("drop_gnt_c8", bus.gnt, 4'b0100);
        go_to(9);
        check("drop_gnt_c9", bus.gnt, 4'b0000);
        go_to(10);
        check("drop_busy_c10", bus.busy, 1'b0);

        // Pointer parked at 3: req 1001 wraps to channel 0, then returns to 3.
        do_reset(4'b1000);
        go_to(1);
        check("wrap_id_c1", bus.gnt_id, 3);
        go_to(2);
        bus.req = 4'b1001;
        go_to(10);
        check("wrap_gnt_c10", bus.gnt,    4'b0001);
        check("wrap_id_c10",  bus.gnt_id, 0);
        go_to(19);
        check("wrap_gnt_c19", bus.gnt,    4'b1000);
        check("wrap_id_c19",  bus.gnt_id, 3);
        go_to(20);
        bus.req = '0;

        // Reset in the middle of a pulse truncates it with no gap.
        do_reset(4'b0010);
        go_to(4);
        reset = 1'b0;
        go_to(5);
        check("midrst_gnt_c5",  bus.gnt,    4'b0000);
        check("midrst_busy_c5", bus.busy,   1'b0);
        check("midrst_id_c5",   bus.gnt_id, 0);
        reset = 1'b1;
        go_to(6);
        check("midrst_gnt_c6",  bus.gnt,    4'b0010);
        check("midrst_id_c6",   bus.gnt_id, 1);
        go_to(13);
        check("midrst_gnt_c13", bus.gnt,    4'b0010);
        go_to(14);
        check("midrst_gnt_c14", bus.gnt,    4'b0000);

        // Randomized requests and occasional resets, checked by the compare process.
        do_reset('0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            reset = ($urandom_range(0, 299) != 0);
        end
        reset   = 1'b1;
        bus.req = '0;
        repeat (GNT_LEN + GAP + 2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
